// File: rtl/gobang_ai_controller.sv
// Move-request sequencer for the gobang strategy engine: clears it, runs one
// full-board scan, picks attack or defence from the two best cells, offers the move.
module gobang_ai_controller #(
    parameter int          BOARD_SIZE   = 15,
    parameter int          SCORE_W      = 13,
    parameter int          WIN_SCORE    = 4096,
    parameter int          THREAT_SCORE = 1024,
    parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               abort,
    input  logic               ai_black,
    output logic               busy,
    output logic               strat_clr,
    output logic               strat_active,
    output logic               strat_random,
    input  logic [SCORE_W-1:0] black_best_score,
    input  logic [3:0]         black_best_i,
    input  logic [3:0]         black_best_j,
    input  logic [SCORE_W-1:0] white_best_score,
    input  logic [3:0]         white_best_i,
    input  logic [3:0]         white_best_j,
    output logic               move_valid,
    input  logic               move_ready,
    output logic [3:0]         move_i,
    output logic [3:0]         move_j,
    output logic               move_attack
);

    localparam int                 CELLS     = BOARD_SIZE * BOARD_SIZE;
    localparam int                 CNT_W     = $clog2(CELLS);
    localparam logic [CNT_W-1:0]   LAST_CELL = CNT_W'(CELLS - 1);
    localparam logic [3:0]         MID       = 4'(BOARD_SIZE / 2);
    localparam logic [SCORE_W-1:0] WIN_TH    = SCORE_W'(WIN_SCORE);
    localparam logic [SCORE_W-1:0] THREAT_TH = SCORE_W'(THREAT_SCORE);

    typedef enum logic [2:0] {IDLE, CLEAR, ARM, SCAN, DECIDE, OFFER} state_t;

    typedef struct packed {
        logic       attack;
        logic [3:0] i;
        logic [3:0] j;
    } move_t;

    state_t           state;
    logic [CNT_W-1:0] scan_cnt;
    logic [15:0]      lfsr;
    logic             ai_black_q;
    move_t            decision;

    // Attack/defence choice; earlier rules take priority, compares are unsigned.
    function automatic move_t decide(
        input logic               blk,
        input logic [SCORE_W-1:0] bs,
        input logic [3:0]         bi,
        input logic [3:0]         bj,
        input logic [SCORE_W-1:0] ws,
        input logic [3:0]         wi,
        input logic [3:0]         wj
    );
        logic [SCORE_W-1:0] my;
        logic [SCORE_W-1:0] op;
        move_t              own;
        move_t              opp;
        my  = blk ? bs : ws;
        op  = blk ? ws : bs;
        own = '{attack: 1'b1, i: (blk ? bi : wi), j: (blk ? bj : wj)};
        opp = '{attack: 1'b0, i: (blk ? wi : bi), j: (blk ? wj : bj)};
        if (my >= WIN_TH)
            return own;
        else if (op >= WIN_TH)
            return opp;
        else if (op >= THREAT_TH && op > my)
            return opp;
        else if (my >= op)
            return own;
        else
            return opp;
    endfunction

    assign decision = decide(ai_black_q, black_best_score, black_best_i, black_best_j,
                             white_best_score, white_best_i, white_best_j);

    // Fibonacci LFSR, taps 16,14,13,11 in right-shifting form; bit 0 feeds the engine.
    always_ff @(posedge clk) begin
        if (rst)
            lfsr <= LFSR_SEED;
        else
            lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
    end

    assign strat_random = lfsr[0];

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            busy         <= 1'b0;
            strat_clr    <= 1'b0;
            strat_active <= 1'b0;
            move_valid   <= 1'b0;
            move_i       <= MID;
            move_j       <= MID;
            move_attack  <= 1'b0;
            scan_cnt     <= '0;
            ai_black_q   <= 1'b0;
        end else if (abort) begin
            // Abort also clears the engine so a restarted game begins clean.
            state        <= IDLE;
            busy         <= 1'b0;
            strat_clr    <= 1'b1;
            strat_active <= 1'b0;
            move_valid   <= 1'b0;
            scan_cnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    strat_clr <= 1'b0;
                    if (start) begin
                        ai_black_q <= ai_black;
                        busy       <= 1'b1;
                        strat_clr  <= 1'b1;
                        state      <= CLEAR;
                    end
                end
                CLEAR: begin
                    strat_clr <= 1'b0;
                    state     <= ARM;
                end
                ARM: begin
                    strat_active <= 1'b1;
                    scan_cnt     <= '0;
                    state        <= SCAN;
                end
                SCAN: begin
                    if (scan_cnt == LAST_CELL) begin
                        strat_active <= 1'b0;
                        scan_cnt     <= '0;
                        state        <= DECIDE;
                    end else begin
                        scan_cnt <= scan_cnt + 1'b1;
                    end
                end
                DECIDE: begin
                    move_i      <= decision.i;
                    move_j      <= decision.j;
                    move_attack <= decision.attack;
                    move_valid  <= 1'b1;
                    state       <= OFFER;
                end
                OFFER: begin
                    if (move_ready) begin
                        move_valid <= 1'b0;
                        busy       <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_gobang_ai_controller.sv
// Bench for gobang_ai_controller: directed and randomized move requests checked
// against a rule-level decision model, cycle timing and an LFSR sequence model.
module tb_gobang_ai_controller;

    localparam int          SCORE_W = 13;
    localparam logic [15:0] SEED    = 16'hACE1;

    logic               clk = 1'b0;
    logic               rst, start, abort, ai_black, move_ready;
    logic               busy, strat_clr, strat_active, strat_random;
    logic [SCORE_W-1:0] black_best_score, white_best_score;
    logic [3:0]         black_best_i, black_best_j, white_best_i, white_best_j;
    logic               move_valid, move_attack;
    logic [3:0]         move_i, move_j;

    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    int          cyc    = 0;
    int unsigned lfsr_m = SEED;

    gobang_ai_controller dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .ai_black(ai_black),
        .busy(busy), .strat_clr(strat_clr), .strat_active(strat_active),
        .strat_random(strat_random),
        .black_best_score(black_best_score), .black_best_i(black_best_i),
        .black_best_j(black_best_j),
        .white_best_score(white_best_score), .white_best_i(white_best_i),
        .white_best_j(white_best_j),
        .move_valid(move_valid), .move_ready(move_ready),
        .move_i(move_i), .move_j(move_j), .move_attack(move_attack)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp)
            n_pass++;
        else
            $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
    endtask

    // One clock: advance the software LFSR, then sample 1ns after the edge.
    task automatic step();
        logic r;
        int unsigned fb;
        r = rst;
        @(posedge clk);
        #1;
        cyc++;
        if (r) begin
            lfsr_m = SEED;
        end else begin
            fb     = (lfsr_m ^ (lfsr_m >> 2) ^ (lfsr_m >> 3) ^ (lfsr_m >> 5)) & 1;
            lfsr_m = (lfsr_m >> 1) | (fb << 15);
        end
        chk("strat_random", strat_random, lfsr_m & 1);
    endtask

    // Reference decision: a winning own cell first, then a winning opponent
    // cell, otherwise whichever side scores strictly higher (ties go to attack).
    task automatic model(input logic blk,
                         input int bs, input int bi, input int bj,
                         input int ws, input int wi, input int wj,
                         output int ei, output int ej, output int ea);
        int my, op;
        my = blk ? bs : ws;
        op = blk ? ws : bs;
        if (my >= 4096 || (op < 4096 && op <= my)) begin
            ea = 1; ei = blk ? bi : wi; ej = blk ? bj : wj;
        end else begin
            ea = 0; ei = blk ? wi : bi; ej = blk ? wj : bj;
        end
    endtask

    function automatic int pick_score();
        int unsigned k;
        k = $urandom_range(0, 7);
        case (k)
            0: return 0;
            1: return 1023 + int'($urandom_range(0, 2));
            2: return 4095 + int'($urandom_range(0, 2));
            3: return int'($urandom_range(0, 1023));
            4: return int'($urandom_range(1024, 4095));
            5: return int'($urandom_range(4096, 8191));
            default: return int'($urandom_range(0, 8191));
        endcase
    endfunction

    task automatic run_move(input logic blk,
                            input int bs, input int bi, input int bj,
                            input int ws, input int wi, input int wj,
                            input int hold, input logic poke);
        int ei, ej, ea, act_cnt, first_clr, first_act;
        logic [3:0] hi, hj;
        model(blk, bs, bi, bj, ws, wi, wj, ei, ej, ea);
        black_best_score = SCORE_W'(bs); black_best_i = 4'(bi); black_best_j = 4'(bj);
        white_best_score = SCORE_W'(ws); white_best_i = 4'(wi); white_best_j = 4'(wj);
        ai_black = blk;
        start = 1'b1;
        cyc = 0; act_cnt = 0; first_clr = 0; first_act = 0;
        step();
        start = 1'b0;
        ai_black = ~blk;
        chk("busy_after_start", busy, 1);
        while (!move_valid && cyc < 400) begin
            if (strat_clr && first_clr == 0) first_clr = cyc;
            if (strat_active) begin
                act_cnt++;
                if (first_act == 0) first_act = cyc;
            end
            step();
        end
        chk("valid_latency", cyc, 229);
        chk("active_cycles", act_cnt, 225);
        chk("clr_cycle", first_clr, 1);
        chk("clr_to_active", first_act - first_clr, 2);
        chk("move_i", move_i, ei);
        chk("move_j", move_j, ej);
        chk("move_attack", move_attack, ea);
        hi = move_i; hj = move_j;
        for (int k = 0; k < hold; k++) begin
            if (poke && k == 1) start = 1'b1;
            step();
            start = 1'b0;
            chk("hold_valid", move_valid, 1);
            chk("hold_i", move_i, hi);
            chk("hold_j", move_j, hj);
        end
        move_ready = 1'b1;
        step();
        move_ready = 1'b0;
        chk("valid_after_hs", move_valid, 0);
        chk("busy_after_hs", busy, 0);
        step();
        chk("busy_idle", busy, 0);
        chk("keep_i", move_i, hi);
    endtask

    initial begin
        int bs, ws;
        rst = 1'b1; start = 1'b0; abort = 1'b0; ai_black = 1'b0; move_ready = 1'b0;
        black_best_score = '0; white_best_score = '0;
        black_best_i = '0; black_best_j = '0; white_best_i = '0; white_best_j = '0;
        repeat (3) step();
        chk("rst_busy", busy, 0);
        chk("rst_clr", strat_clr, 0);
        chk("rst_active", strat_active, 0);
        chk("rst_valid", move_valid, 0);
        chk("rst_move_i", move_i, 7);
        chk("rst_move_j", move_j, 7);
        chk("rst_attack", move_attack, 0);
        rst = 1'b0;
        step();

        run_move(1'b1, 0, 7, 7, 0, 7, 7, 0, 1'b0);
        run_move(1'b0, 6000, 9, 9, 5000, 3, 4, 2, 1'b0);
        run_move(1'b1, 800, 2, 2, 2000, 5, 6, 1, 1'b0);
        run_move(1'b1, 800, 2, 2, 900, 5, 6, 0, 1'b0);
        run_move(1'b0, 1024, 1, 2, 1024, 3, 4, 10, 1'b1);
        run_move(1'b1, 4095, 0, 14, 4096, 14, 0, 3, 1'b0);

        // Abort mid-scan at scan index 100 (cycle 103 after the accepting edge).
        ai_black = 1'b1; start = 1'b1; cyc = 0;
        step();
        start = 1'b0;
        while (cyc < 103) step();
        chk("abort_pre_active", strat_active, 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("abort_busy", busy, 0);
        chk("abort_clr", strat_clr, 1);
        chk("abort_active", strat_active, 0);
        chk("abort_valid", move_valid, 0);
        step();
        chk("abort_clr_pulse", strat_clr, 0);
        chk("abort_idle_busy", busy, 0);
        run_move(1'b1, 300, 4, 4, 200, 6, 6, 0, 1'b0);

        // Abort arriving together with start wins.
        start = 1'b1; abort = 1'b1;
        step();
        start = 1'b0; abort = 1'b0;
        chk("abort_start_busy", busy, 0);
        chk("abort_start_clr", strat_clr, 1);
        step();

        for (int n = 0; n < 10; n++) begin
            bs = pick_score();
            ws = pick_score();
            run_move(1'($urandom_range(0, 1)),
                     bs, int'($urandom_range(0, 14)), int'($urandom_range(0, 14)),
                     ws, int'($urandom_range(0, 14)), int'($urandom_range(0, 14)),
                     int'($urandom_range(0, 4)), 1'($urandom_range(0, 1)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
